l15_responder: RTL and testbench
================================

// Module: l15_responder
// PURPOSE
//  L1.5-side responder for the core's transducer request interface; used as the memory-side stub in core-level sims.
//  Accepts one request per handshake (imiss, load, store) from the core's arbitrated transducer port.
//  Serves requests from an internal doubleword memory and returns data with the matching returntype.
//  Holds each response until the core acknowledges it on transducer_l15_req_ack.
// PARAMETERS
//  MEM_AW    10   log2 of memory depth in 64-bit doublewords
//  RESP_LAT  2    extra WAIT cycles between ack and response valid (0 allowed)
//  INIT_FILE ""   optional $readmemh image; memory is X/zero if empty
// PORTS
//  clk                         in   1   clock
//  rst                         in   1   synchronous reset, active-high
//  transducer_l15_rqtype       in   5   request type
//  transducer_l15_size         in   3   access size code
//  transducer_l15_address      in   40  byte address
//  transducer_l15_data         in   64  store data, byte lane = address[2:0]
//  transducer_l15_val          in   1   request valid, held by core until ack
//  l15_transducer_ack          out  1   request accepted (1-cycle pulse)
//  l15_transducer_header_ack   out  1   header accepted (pulses with ack)
//  l15_transducer_val          out  1   response valid, held until req_ack
//  l15_transducer_data_0       out  64  response doubleword 0
//  l15_transducer_data_1       out  64  response doubleword 1
//  l15_transducer_returntype   out  4   response type
//  transducer_l15_req_ack      in   1   core consumed response
//  resp_error                  out  1   sticky: unsupported rqtype/size seen
// BEHAVIOUR
//  - Reset: all outputs 0, FSM to IDLE, latched request cleared; memory contents preserved.
//  - FSM: IDLE -> ACK -> WAIT -> RESP -> IDLE.
//    IDLE: transducer_l15_val=1 latches rqtype/size/address/data; go ACK.
//    ACK (1 cycle): ack=header_ack=1; stores commit to memory this cycle; go WAIT.
//    WAIT: counts RESP_LAT cycles; RESP_LAT=0 skips straight to RESP.
//    RESP: l15_transducer_val=1, data/returntype stable; req_ack=1 -> IDLE next cycle.
//  - Latency: val sampled at cycle N -> ack at N+1 -> response valid at N+2+RESP_LAT.
//  - Back-to-back: one IDLE cycle between a completed response and the next accept.
//  - Requests are ignored outside IDLE; the core must keep val high.
//  - Memory index: doubleword index = address[MEM_AW+2:3]; upper bits ignored (aliasing wrap).
//  - IMISS (5'b10000): returns doublewords address[MEM_AW+2:4]*2 and *2+1 on data_0/data_1 (16B aligned); returntype IFILL_RET 4'b0001.
//  - LOAD (5'b00000): data_0 = full doubleword containing address; data_1 = 0; returntype LOAD_RET 4'b0000.
//  - STORE (5'b00001): byte enables from size (1B=3'b000, 2B=3'b001, 4B=3'b010, 8B=3'b011) shifted by address[2:0].
//    Misaligned stores are dropped (no write) and set resp_error; ack still given; returntype ST_ACK 4'b0100, data 0.
//  - Any other rqtype: acked; response LOAD_RET with data 0; resp_error set (cleared only by rst).
//  - req_ack while not in RESP: ignored.
//  - rst mid-request: abandons it; an uncommitted store is not written.
// CONFIGURATION
//  L15_RESP_STALL_EN defined:
//   - 8-bit LFSR (seed 8'hA5 on rst) adds 0..7 extra WAIT cycles per request; value is LFSR[2:0] at accept.
//   - Exercises the core arbiter's arb_wait/arb_mem paths.
//  L15_RESP_STALL_EN undefined: WAIT length is exactly RESP_LAT.
// STRUCTURE
//  Shared package l15_resp_pkg:
//   - rqtype constants (IMISS/LOAD/STORE), returntype constants (LOAD_RET/IFILL_RET/ST_ACK)
//   - size codes
//   - FSM state enum, 2 bits
//  Sub-module l15_resp_mem:
//   - 2^MEM_AW x 64 array
//   - one byte-enable write port; two combinational read ports (even/odd doubleword)
// TESTING
//  - LOAD addr 0x40, mem[8]=64'h1122334455667788, RESP_LAT=2 -> ack at N+1; val at N+4; data_0=1122334455667788; rtype 0.
//  - STORE 4B addr 0x44, data 64'hDEADBEEF_00000000 -> ST_ACK; following LOAD 0x40 returns DEADBEEF_55667788.
//  - IMISS addr 0x108 -> data_0=mem[0x20], data_1=mem[0x21]; returntype 4'b0001.
//  - Response held: req_ack low 5 cycles -> val and data stable; req_ack=1 -> val=0 next cycle; new val accepted one cycle later.
//  - STORE 2B addr 0x3, rqtype 5'b00111 -> resp_error=1; memory unchanged; both requests still acked and responded.
//  - rst asserted in WAIT after STORE accept vs before ACK -> outputs 0 next cycle; store visible only if ACK completed.

Source files
------------

// File: rtl/l15_resp_pkg.sv
// Shared definitions for the L1.5 responder stub.
// Holds the transducer request and return type encodings, the access size codes,
// the responder FSM state type, and helpers that turn a store size/offset pair
// into a byte-enable mask and an alignment verdict.
package l15_resp_pkg;

    // Request types issued by the core's transducer
    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_STORE = 5'b00001;
    localparam logic [4:0] RQ_IMISS = 5'b10000;

    // Return types placed on l15_transducer_returntype
    localparam logic [3:0] RT_LOAD_RET  = 4'b0000;
    localparam logic [3:0] RT_IFILL_RET = 4'b0001;
    localparam logic [3:0] RT_ST_ACK    = 4'b0100;

    // Access size codes
    localparam logic [2:0] SZ_1B = 3'b000;
    localparam logic [2:0] SZ_2B = 3'b001;
    localparam logic [2:0] SZ_4B = 3'b010;
    localparam logic [2:0] SZ_8B = 3'b011;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Byte-enable mask for a store of the given size starting at byte offset.
    // Unsupported size codes yield an empty mask.
    function automatic logic [7:0] store_byte_en(input logic [2:0] size,
                                                 input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_1B:   base = 8'h01;
            SZ_2B:   base = 8'h03;
            SZ_4B:   base = 8'h0F;
            SZ_8B:   base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << offset;
    endfunction

    // A store is usable only with a supported size that is naturally aligned.
    function automatic logic store_ok(input logic [2:0] size,
                                      input logic [2:0] offset);
        logic ok;
        case (size)
            SZ_1B:   ok = 1'b1;
            SZ_2B:   ok = (offset[0] == 1'b0);
            SZ_4B:   ok = (offset[1:0] == 2'b00);
            SZ_8B:   ok = (offset == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// Doubleword backing store for the L1.5 responder stub.
// Ports:
//   clk                      clock
//   wr_en, wr_idx, wr_be     byte-enabled write of wr_data into doubleword wr_idx
//   rd_idx_0 / rd_data_0     combinational read port feeding response doubleword 0
//   rd_idx_1 / rd_data_1     combinational read port feeding response doubleword 1
// Contents are not reset; they survive a responder reset.
module l15_resp_mem #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_idx,
    input  logic [7:0]        wr_be,
    input  logic [63:0]       wr_data,
    input  logic [MEM_AW-1:0] rd_idx_0,
    input  logic [MEM_AW-1:0] rd_idx_1,
    output logic [63:0]       rd_data_0,
    output logic [63:0]       rd_data_1
);

    logic [63:0] mem [2**MEM_AW];

    // Byte-granular write: only lanes with their enable set are updated,
    // the rest of the doubleword keeps its previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Both read ports are asynchronous so the response is available as soon
    // as the FSM reaches RESP.
    assign rd_data_0 = mem[rd_idx_0];
    assign rd_data_1 = mem[rd_idx_1];

endmodule

// File: rtl/l15_responder.sv
// L1.5-side responder stub for the core's transducer request interface.
// Accepts one imiss/load/store per handshake, serves it from an internal
// doubleword memory and holds the response until the core acknowledges it.
// Parameters:
//   MEM_AW    log2 of memory depth in 64-bit doublewords
//   RESP_LAT  extra WAIT cycles between ack and response valid (0 allowed)
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   transducer_l15_rqtype/size/
//     address/data/val               request from the core, val held until ack
//   l15_transducer_ack/header_ack    one-cycle accept pulse
//   l15_transducer_val               response valid, held until req_ack
//   l15_transducer_data_0/_1         response doublewords
//   l15_transducer_returntype        response type
//   transducer_l15_req_ack           core consumed the response
//   resp_error                       sticky flag for unsupported rqtype/size or misaligned store
// Build option: define L15_RESP_STALL_EN to add a pseudo-random 0..7 cycle stall
// per request from an 8-bit LFSR.
module l15_responder
    import l15_resp_pkg::*;
#(
    parameter int MEM_AW   = 10,
    parameter int RESP_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  transducer_l15_rqtype,
    input  logic [2:0]  transducer_l15_size,
    input  logic [39:0] transducer_l15_address,
    input  logic [63:0] transducer_l15_data,
    input  logic        transducer_l15_val,
    output logic        l15_transducer_ack,
    output logic        l15_transducer_header_ack,
    output logic        l15_transducer_val,
    output logic [63:0] l15_transducer_data_0,
    output logic [63:0] l15_transducer_data_1,
    output logic [3:0]  l15_transducer_returntype,
    input  logic        transducer_l15_req_ack,
    output logic        resp_error
);

    localparam logic [7:0] LAT = 8'(RESP_LAT);

    state_t              state;
    state_t              state_next;
    logic [4:0]          req_rqtype;
    logic [2:0]          req_size;
    logic [MEM_AW+2:0]   req_addr;
    logic [63:0]         req_data;
    logic [7:0]          wait_cnt;
    logic [7:0]          extra_wait;
    logic                accept;
    logic                is_load;
    logic                is_store;
    logic                is_imiss;
    logic                store_good;
    logic                req_bad;
    logic                mem_wr_en;
    logic [MEM_AW-1:0]   rd_idx_0;
    logic [MEM_AW-1:0]   rd_idx_1;
    logic [63:0]         rd_data_0;
    logic [63:0]         rd_data_1;
    logic                unused_addr_bits;

    // Address bits above the memory index alias onto the same doublewords.
    assign unused_addr_bits = ^transducer_l15_address[39:MEM_AW+3];

`ifdef L15_RESP_STALL_EN
    logic [7:0] lfsr;

    // Free-running maximal-length LFSR; its low three bits at accept time
    // become the extra stall for that request.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra_wait = {5'd0, lfsr[2:0]};
`else
    assign extra_wait = 8'd0;
`endif

    assign accept = (state == ST_IDLE) && transducer_l15_val;

    // Decode of the latched request
    assign is_load    = (req_rqtype == RQ_LOAD);
    assign is_store   = (req_rqtype == RQ_STORE);
    assign is_imiss   = (req_rqtype == RQ_IMISS);
    assign store_good = store_ok(req_size, req_addr[2:0]);
    assign req_bad    = !(is_load || is_store || is_imiss) || (is_store && !store_good);

    // Stores commit on the edge that ends ACK; a reset on that same edge
    // abandons the request before anything reaches memory.
    assign mem_wr_en = (state == ST_ACK) && is_store && store_good && !rst;

    // An instruction fill returns the 16-byte aligned pair; a load returns
    // the doubleword holding the address on port 0.
    assign rd_idx_0 = is_imiss ? {req_addr[MEM_AW+2:4], 1'b0} : req_addr[MEM_AW+2:3];
    assign rd_idx_1 = {req_addr[MEM_AW+2:4], 1'b1};

    l15_resp_mem #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk       (clk),
        .wr_en     (mem_wr_en),
        .wr_idx    (req_addr[MEM_AW+2:3]),
        .wr_be     (store_byte_en(req_size, req_addr[2:0])),
        .wr_data   (req_data),
        .rd_idx_0  (rd_idx_0),
        .rd_idx_1  (rd_idx_1),
        .rd_data_0 (rd_data_0),
        .rd_data_1 (rd_data_1)
    );

    // State register, request latch, WAIT counter and the sticky error flag.
    // The counter is loaded at accept with the whole WAIT length so that the
    // stall value is fixed for the lifetime of the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_rqtype <= '0;
            req_size   <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            wait_cnt   <= '0;
            resp_error <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_rqtype <= transducer_l15_rqtype;
                req_size   <= transducer_l15_size;
                req_addr   <= transducer_l15_address[MEM_AW+2:0];
                req_data   <= transducer_l15_data;
                wait_cnt   <= LAT + extra_wait;
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
            if ((state == ST_ACK) && req_bad) begin
                resp_error <= 1'b1;
            end
        end
    end

    // Next-state logic. WAIT is entered only when the loaded count is non-zero
    // and is left on the cycle the count reaches one.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (transducer_l15_val)     state_next = ST_ACK;
            ST_ACK:  state_next = (wait_cnt == 8'd0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wait_cnt == 8'd1)       state_next = ST_RESP;
            ST_RESP: if (transducer_l15_req_ack) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state so they are all zero after reset
    // and remain stable for as long as RESP is held.
    always_comb begin
        l15_transducer_ack        = (state == ST_ACK);
        l15_transducer_header_ack = (state == ST_ACK);
        l15_transducer_val        = (state == ST_RESP);
        l15_transducer_data_0     = 64'd0;
        l15_transducer_data_1     = 64'd0;
        l15_transducer_returntype = RT_LOAD_RET;
        if (state == ST_RESP) begin
            if (is_imiss) begin
                l15_transducer_data_0     = rd_data_0;
                l15_transducer_data_1     = rd_data_1;
                l15_transducer_returntype = RT_IFILL_RET;
            end else if (is_load) begin
                l15_transducer_data_0     = rd_data_0;
            end else if (is_store) begin
                l15_transducer_returntype = RT_ST_ACK;
            end
        end
    end

endmodule

// File: tb/tb_l15_responder.sv
// Self-checking bench for l15_responder: a table of requests with expected
// responses, a scoreboard queue filled when each request is accepted and
// drained when the response appears, plus hand-written sequences for response
// holding, back-to-back accept and reset in the middle of a request.
module tb_l15_responder;
    import l15_resp_pkg::*;

    localparam int MEM_AW   = 10;
    localparam int RESP_LAT = 2;

    logic        clk;
    logic        rst;
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [39:0] address;
    logic [63:0] wdata;
    logic        req_val;
    logic        ack;
    logic        header_ack;
    logic        resp_val;
    logic [63:0] data_0;
    logic [63:0] data_1;
    logic [3:0]  returntype;
    logic        req_ack;
    logic        resp_error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rq;
        logic [2:0]  sz;
        logic [39:0] addr;
        logic [63:0] wd;
        logic [3:0]  rt;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0]  rt;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        err;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    l15_responder #(
        .MEM_AW   (MEM_AW),
        .RESP_LAT (RESP_LAT)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .transducer_l15_rqtype     (rqtype),
        .transducer_l15_size       (size),
        .transducer_l15_address    (address),
        .transducer_l15_data       (wdata),
        .transducer_l15_val        (req_val),
        .l15_transducer_ack        (ack),
        .l15_transducer_header_ack (header_ack),
        .l15_transducer_val        (resp_val),
        .l15_transducer_data_0     (data_0),
        .l15_transducer_data_1     (data_1),
        .l15_transducer_returntype (returntype),
        .transducer_l15_req_ack    (req_ack),
        .resp_error                (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic checkLatency(input string name, input int act, input int req);
`ifdef L15_RESP_STALL_EN
        check(name, 64'((act >= req) && (act <= req + 7)), 64'd1);
`else
        check(name, 64'(act), 64'(req));
`endif
    endtask

    // Drive one request from the current cycle, wait for the accept pulse,
    // drop val and record the expected response.
    task automatic applyStimulus(input logic [4:0] rq, input logic [2:0] sz,
                                 input logic [39:0] addr, input logic [63:0] wd,
                                 input logic [3:0] rt, input logic [63:0] d0,
                                 input logic [63:0] d1, input logic err);
        int cycles;
        exp_t e;
        rqtype  = rq;
        size    = sz;
        address = addr;
        wdata   = wd;
        req_val = 1'b1;
        cycles  = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!ack && cycles < 20);
        check("ack", 64'(ack), 64'd1);
        check("header_ack", 64'(header_ack), 64'd1);
        check("ack_latency", 64'(cycles), 64'd1);
        req_val = 1'b0;
        e.rt  = rt;
        e.d0  = d0;
        e.d1  = d1;
        e.err = err;
        sb.push_back(e);
    endtask

    // Wait for the response, compare it with the oldest scoreboard entry,
    // optionally hold it, then consume it and confirm val drops.
    task automatic checkOutput(input int exp_lat, input int hold_cycles);
        int lat;
        exp_t e;
        lat = 0;
        while (!resp_val && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_valid", 64'(resp_val), 64'd1);
        checkLatency("resp_latency", lat, exp_lat);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("returntype", 64'(returntype), 64'(e.rt));
            check("data_0", data_0, e.d0);
            check("data_1", data_1, e.d1);
            check("resp_error", 64'(resp_error), 64'(e.err));
            for (int h = 0; h < hold_cycles; h++) begin
                @(posedge clk);
                #1;
                check("hold_val", 64'(resp_val), 64'd1);
                check("hold_data_0", data_0, e.d0);
                check("hold_returntype", 64'(returntype), 64'(e.rt));
            end
        end
        req_ack = 1'b1;
        @(posedge clk);
        #1;
        req_ack = 1'b0;
        check("val_drop", 64'(resp_val), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rqtype  = '0;
        size    = '0;
        address = '0;
        wdata   = '0;
        req_val = 1'b0;
        req_ack = 1'b0;

        vecs[0]  = '{RQ_STORE, SZ_8B, 40'h40,   64'h1122334455667788, RT_ST_ACK,    64'd0,                64'd0,                1'b0};
        vecs[1]  = '{RQ_LOAD,  SZ_8B, 40'h40,   64'd0,                RT_LOAD_RET,  64'h1122334455667788, 64'd0,                1'b0};
        vecs[2]  = '{RQ_STORE, SZ_4B, 40'h44,   64'hDEADBEEF00000000, RT_ST_ACK,    64'd0,                64'd0,                1'b0};
        vecs[3]  = '{RQ_LOAD,  SZ_8B, 40'h40,   64'd0,                RT_LOAD_RET,  64'hDEADBEEF55667788, 64'd0,                1'b0};
        vecs[4]  = '{RQ_STORE, SZ_8B, 40'h100,  64'hA0A1A2A3A4A5A6A7, RT_ST_ACK,    64'd0,                64'd0,                1'b0};
        vecs[5]  = '{RQ_STORE, SZ_8B, 40'h108,  64'hB0B1B2B3B4B5B6B7, RT_ST_ACK,    64'd0,                64'd0,                1'b0};
        vecs[6]  = '{RQ_IMISS, SZ_8B, 40'h108,  64'd0,                RT_IFILL_RET, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 1'b0};
        vecs[7]  = '{RQ_STORE, SZ_1B, 40'h41,   64'h000000000000CC00, RT_ST_ACK,    64'd0,                64'd0,                1'b0};
        vecs[8]  = '{RQ_LOAD,  SZ_8B, 40'h2044, 64'd0,                RT_LOAD_RET,  64'hDEADBEEF5566CC88, 64'd0,                1'b0};
        vecs[9]  = '{RQ_STORE, SZ_8B, 40'h0,    64'h0123456789ABCDEF, RT_ST_ACK,    64'd0,                64'd0,                1'b0};
        vecs[10] = '{RQ_STORE, SZ_2B, 40'h3,    64'hFFFFFFFFFFFFFFFF, RT_ST_ACK,    64'd0,                64'd0,                1'b1};
        vecs[11] = '{RQ_LOAD,  SZ_8B, 40'h0,    64'd0,                RT_LOAD_RET,  64'h0123456789ABCDEF, 64'd0,                1'b1};
        vecs[12] = '{5'b00111, SZ_2B, 40'h3,    64'h5A5A5A5A5A5A5A5A, RT_LOAD_RET,  64'd0,                64'd0,                1'b1};
        vecs[13] = '{RQ_STORE, 3'b100, 40'h10,  64'h1234,             RT_ST_ACK,    64'd0,                64'd0,                1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_header_ack", 64'(header_ack), 64'd0);
        check("reset_val", 64'(resp_val), 64'd0);
        check("reset_data_0", data_0, 64'd0);
        check("reset_returntype", 64'(returntype), 64'd0);
        check("reset_error", 64'(resp_error), 64'd0);

        $display("[TB] table-driven requests");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rq, vecs[i].sz, vecs[i].addr, vecs[i].wd,
                          vecs[i].rt, vecs[i].d0, vecs[i].d1, vecs[i].err);
            checkOutput(1 + RESP_LAT, 0);
        end

        $display("[TB] held response, stray req_ack, back-to-back accept");
        applyStimulus(RQ_LOAD, SZ_8B, 40'h40, 64'd0, RT_LOAD_RET, 64'hDEADBEEF5566CC88, 64'd0, 1'b1);
        req_ack = 1'b1;
        @(posedge clk);
        #1;
        req_ack = 1'b0;
        checkOutput(RESP_LAT, 5);
        applyStimulus(RQ_IMISS, SZ_8B, 40'h10C, 64'd0, RT_IFILL_RET, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 1'b1);
        checkOutput(1 + RESP_LAT, 0);

        $display("[TB] reset in WAIT after a store was acked");
        applyStimulus(RQ_STORE, SZ_8B, 40'h80, 64'h5555666677778888, RT_ST_ACK, 64'd0, 64'd0, 1'b1);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstwait_val", 64'(resp_val), 64'd0);
        check("rstwait_ack", 64'(ack), 64'd0);
        check("rstwait_error", 64'(resp_error), 64'd0);
        applyStimulus(RQ_LOAD, SZ_8B, 40'h80, 64'd0, RT_LOAD_RET, 64'h5555666677778888, 64'd0, 1'b0);
        checkOutput(1 + RESP_LAT, 0);

        $display("[TB] reset during ACK drops the store");
        applyStimulus(RQ_STORE, SZ_8B, 40'h88, 64'h7777777777777777, RT_ST_ACK, 64'd0, 64'd0, 1'b0);
        checkOutput(1 + RESP_LAT, 0);
        rqtype  = RQ_STORE;
        size    = SZ_8B;
        address = 40'h88;
        wdata   = 64'h9999999999999999;
        req_val = 1'b1;
        @(posedge clk);
        #1;
        check("rstack_ack", 64'(ack), 64'd1);
        req_val = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstack_ack_cleared", 64'(ack), 64'd0);
        check("rstack_val", 64'(resp_val), 64'd0);
        applyStimulus(RQ_LOAD, SZ_8B, 40'h88, 64'd0, RT_LOAD_RET, 64'h7777777777777777, 64'd0, 1'b0);
        checkOutput(1 + RESP_LAT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
